// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - EX-stage ALU with iterative multiply/divide engine and HI/LO registers
// Single-cycle ops finish one cycle after accept; MUL/DIV step a shared 2*WIDTH work register.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             md_signed,
  input  logic [WIDTH-1:0] alusrc_1,
  input  logic [WIDTH-1:0] alusrc_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MFLO = 4'd12;
  localparam logic [3:0] OP_MTHI = 4'd13;
  localparam logic [3:0] OP_MTLO = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]     opd_q, opd_d;
  logic [2*WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]     alu_out_q, alu_out_d;
  logic                 zero_q, zero_d;
  logic                 overflow_q, overflow_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 accept;
  logic                 is_md_op;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sum, dif, single_res;
  logic                 single_ov;

  assign in_ready    = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign is_md_op    = (alu_op == OP_MUL) | (alu_op == OP_DIV);
  assign shamt       = alusrc_1[SHW-1:0];
  assign out_valid   = (state_q == S_DONE);
  assign alu_out     = alu_out_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  always_comb begin
    sum        = alusrc_1 + alusrc_2;
    dif        = alusrc_1 - alusrc_2;
    single_res = '0;
    single_ov  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        single_res = sum;
        single_ov  = (alusrc_1[WIDTH-1] == alusrc_2[WIDTH-1]) &&
                     (sum[WIDTH-1] != alusrc_1[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = dif;
        single_ov  = (alusrc_1[WIDTH-1] != alusrc_2[WIDTH-1]) &&
                     (dif[WIDTH-1] != alusrc_1[WIDTH-1]);
      end
      OP_AND:  single_res = alusrc_1 & alusrc_2;
      OP_OR:   single_res = alusrc_1 | alusrc_2;
      OP_XOR:  single_res = alusrc_1 ^ alusrc_2;
      OP_NOR:  single_res = ~(alusrc_1 | alusrc_2);
      OP_SLL:  single_res = alusrc_2 << shamt;
      OP_SRL:  single_res = alusrc_2 >> shamt;
      OP_SRA:  single_res = $signed(alusrc_2) >>> shamt;
      OP_MFHI: single_res = hi_q;
      OP_MFLO: single_res = lo_q;
      default: single_res = '0;
    endcase
  end

  // Operand conditioning at accept: signed ops iterate on magnitudes and fix signs at the end.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg  = md_signed & alusrc_1[WIDTH-1];
    b_neg  = md_signed & alusrc_2[WIDTH-1];
    b_zero = (alusrc_2 == '0);
    a_mag  = a_neg ? -alusrc_1 : alusrc_1;
    b_mag  = b_neg ? -alusrc_2 : alusrc_2;
  end

  // md_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  logic [WIDTH:0]       mul_sum, div_trial, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   md_step, prod_fin;
  logic [WIDTH-1:0]     quo_fin, rem_fin, md_res;

  always_comb begin
    mul_sum   = {1'b0, md_q[2*WIDTH-1:WIDTH]} + {1'b0, (md_q[0] ? opd_q : {WIDTH{1'b0}})};
    div_trial = {md_q[2*WIDTH-1:WIDTH], md_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opd_q};
    div_ge    = ~div_diff[WIDTH];
    if (is_div_q) begin
      md_step = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]), md_q[WIDTH-2:0], div_ge};
    end else begin
      md_step = {mul_sum, md_q[WIDTH-1:1]};
    end
    prod_fin = neg_lo_q ? -md_step : md_step;
    quo_fin  = neg_lo_q ? -md_step[WIDTH-1:0] : md_step[WIDTH-1:0];
    rem_fin  = neg_hi_q ? -md_step[2*WIDTH-1:WIDTH] : md_step[2*WIDTH-1:WIDTH];
    md_res   = is_div_q ? quo_fin : prod_fin[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    opd_d      = opd_q;
    md_d       = md_q;
    alu_out_d  = alu_out_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_BUSY: begin
        md_d  = md_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d   = S_DONE;
          alu_out_d = md_res;
          zero_d    = (md_res == '0);
          lo_d      = md_res;
          hi_d      = is_div_q ? rem_fin : prod_fin[2*WIDTH-1:WIDTH];
          dbz_d     = is_div_q & (opd_q == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      overflow_d = 1'b0;
      dbz_d      = 1'b0;
      if (is_md_op) begin
        state_d  = S_BUSY;
        cnt_d    = '0;
        is_div_d = (alu_op == OP_DIV);
        opd_d    = b_mag;
        // A zero divisor skips sign handling so the divide naturally yields all-ones / dividend.
        if (alu_op == OP_DIV) begin
          neg_lo_d = (a_neg ^ b_neg) & ~b_zero;
          neg_hi_d = a_neg & ~b_zero;
          md_d     = {{WIDTH{1'b0}}, (b_zero ? alusrc_1 : a_mag)};
        end else begin
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = 1'b0;
          md_d     = {{WIDTH{1'b0}}, a_mag};
        end
      end else begin
        state_d    = S_DONE;
        alu_out_d  = single_res;
        zero_d     = (single_res == '0);
        overflow_d = single_ov;
        if (alu_op == OP_MTHI) hi_d = alusrc_1;
        if (alu_op == OP_MTLO) lo_d = alusrc_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      opd_q      <= '0;
      md_q       <= '0;
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      opd_q      <= opd_d;
      md_q       <= md_d;
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - scoreboard bench for alu_muldiv_unit
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = 4'd15;
  logic         md_signed = 1'b0;
  logic [W-1:0] alusrc_1 = '0;
  logic [W-1:0] alusrc_2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         zero, overflow, div_by_zero;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .md_signed(md_signed), .alusrc_1(alusrc_1), .alusrc_2(alusrc_2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic         ov;
    logic         z;
    logic         dbz;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, output exp_t e);
    logic [63:0]        p;
    logic signed [63:0] sa, sbv, q, rm;
    e.r = '0; e.ov = 1'b0; e.dbz = 1'b0;
    sa  = $signed({{32{a[31]}}, a});
    sbv = $signed({{32{b[31]}}, b});
    case (op)
      4'd0: begin e.r = a + b; e.ov = (a[31] == b[31]) && (e.r[31] != a[31]); end
      4'd1: begin e.r = a - b; e.ov = (a[31] != b[31]) && (e.r[31] != a[31]); end
      4'd2: begin
        if (sg) p = sa * sbv;
        else    p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; e.r = m_lo;
      end
      4'd3: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; e.dbz = 1'b1;
        end else if (sg) begin
          q = sa / sbv; rm = sa % sbv;
          m_lo = q[31:0]; m_hi = rm[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        e.r = m_lo;
      end
      4'd4:  e.r = a & b;
      4'd5:  e.r = a | b;
      4'd6:  e.r = a ^ b;
      4'd7:  e.r = ~(a | b);
      4'd8:  e.r = b << a[4:0];
      4'd9:  e.r = b >> a[4:0];
      4'd10: e.r = $signed(b) >>> a[4:0];
      4'd11: e.r = m_hi;
      4'd12: e.r = m_lo;
      4'd13: m_hi = a;
      4'd14: m_lo = a;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    e.h = m_hi;
    e.l = m_lo;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("alu_out", alu_out, mon_e.r);
        check("hi", hi, mon_e.h);
        check("lo", lo, mon_e.l);
        check("overflow", overflow, mon_e.ov);
        check("zero", zero, mon_e.z);
        check("div_by_zero", div_by_zero, mon_e.dbz);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic sg, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    int   guard = 0;
    exp_t e;
    alu_op = op; md_signed = sg; alusrc_1 = a; alusrc_2 = b; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    model(op, sg, a, b, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int c0;
    int guard;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_zero", zero, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(4'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_valid(lat); check("add_latency", lat, 1);
    drain();

    send(4'd2, 1'b1, 32'hFFFF_FFFD, 32'd5);
    check("mul_busy_in_ready", in_ready, 0);
    wait_valid(lat); check("mul_latency", lat, 33);
    drain();

    send(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_valid(lat); check("div_latency", lat, 33);
    drain();

    send(4'd3, 1'b0, 32'd10, 32'd0);
    wait_valid(lat); check("div0_latency", lat, 33);
    drain();

    send(4'd10, 1'b0, 32'd4, 32'h8000_0000);
    send(4'd9, 1'b0, 32'd4, 32'h8000_0000);
    send(4'd10, 1'b0, 32'h24, 32'h8000_0000);
    send(4'd8, 1'b0, 32'h24, 32'h0000_00F1);
    send(4'd4, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd5, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd6, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd7, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'd1, 1'b0, 32'h8000_0000, 32'd1);
    send(4'd11, 1'b0, 32'd0, 32'd0);
    send(4'd13, 1'b0, 32'hCAFE_0001, 32'd0);
    send(4'd14, 1'b0, 32'hBEEF_0002, 32'd0);
    send(4'd12, 1'b0, 32'd0, 32'd0);
    send(4'd11, 1'b0, 32'd0, 32'd0);
    send(4'd15, 1'b0, 32'h1234_5678, 32'd9);
    send(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    send(4'd3, 1'b1, 32'd7, 32'hFFFF_FFFE);
    send(4'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(4'd2, 1'b1, 32'h8000_0000, 32'h8000_0000);
    send(4'd3, 1'b0, 32'hFFFF_FFF0, 32'd7);
    wait_valid(lat);
    drain();

    c0 = cyc;
    for (int i = 0; i < 4; i++) send(4'd0, 1'b0, 32'(i * 3), 32'd100);
    check("b2b_cycles", cyc - c0, 4);
    drain();

    out_ready = 1'b0;
    send(4'd1, 1'b0, 32'd5, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_alu_out", alu_out, 0);
      check("bp_zero", zero, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    send(4'd2, 1'b0, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_alu_out", alu_out, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd0, 1'b0, 32'd2, 32'd3);
    wait_valid(lat); check("post_rst_latency", lat, 1);
    drain();

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
